fp_accum_seq: RTL and testbench
===============================

# fp_accum_seq

Sequencing front-end that reduces a stream of IEEE-754 single-precision values to one sum per packet. It sits directly upstream of the team's multi-cycle floating-point adder. It drives the adder's operand and start inputs and consumes its result/valid outputs, feeding each partial sum back as the next left operand. It also provides a valid/ready input stream and a one-cycle result strobe to the surrounding datapath (sensor-channel averaging, dot-product tails).

## Interface
Parameters:
- EXP, 8, exponent width (fixed 8 for this release).
- MAN, 23, mantissa width (fixed 23 for this release).
- CNT_W, 8, width of element counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input element present.
- in_ready  out  1  block accepts element this cycle.
- in_data  in  EXP+MAN+1  element bit pattern.
- in_last  in  1  element is last of packet.
- add_a  out  EXP+MAN+1  adder input1 (running sum).
- add_b  out  EXP+MAN+1  adder input2 (new element).
- add_strt  out  1  adder start pulse.
- add_busy  in  1  adder busy.
- add_valid  in  1  adder result strobe.
- add_sum  in  EXP+MAN+1  adder out.
- acc_out  out  EXP+MAN+1  packet sum, held until next result.
- acc_valid  out  1  one-cycle strobe, acc_out new.
- acc_count  out  CNT_W  elements in the reported packet, saturating.

## Operation
- States: IDLE, WAIT_IN, ISSUE, WAIT_ADD, DONE.
- IDLE: in_ready=1. On handshake (in_valid&in_ready):
  - acc <= in_data and cnt <= 1. The first element bypasses the adder.
  - If in_last, go to DONE; else go to WAIT_IN.
- WAIT_IN: in_ready=1. On handshake: add_b <= in_data, last_r <= in_last, cnt <= cnt+1 (saturate at all-ones), go to ISSUE.
- ISSUE: in_ready=0.
  - If add_busy=0: add_strt=1 for exactly this cycle, then go to WAIT_ADD.
  - If add_busy=1: stay in ISSUE and hold add_strt=0.
- WAIT_ADD: in_ready=0; add_strt=0. On add_valid=1:
  - acc <= add_sum.
  - If last_r, go to DONE; else go to WAIT_IN.
- DONE (one cycle): acc_out <= acc, acc_count <= cnt, acc_valid=1, in_ready=0, then go to IDLE.
- add_a always equals acc. add_a and add_b are registered and stable from the ISSUE cycle until add_valid is seen; the adder latches them some cycles after strt.
- add_valid outside WAIT_ADD is ignored.
- The block never modifies bit patterns. Zeros, denormals, Inf and NaN pass to the adder unchanged; numeric correctness is the adder's responsibility.
- Adds are strictly serial: at most one in flight.

## Timing
- Reset values: in_ready=0 while rst is high, then 1 in IDLE. add_strt=0, add_a=0, add_b=0, acc_out=0, acc_valid=0, acc_count=0, state=IDLE.
- Per-element cost after the first: 1 cycle (ISSUE) + adder latency (4 cycles with the current adder: strt at T gives add_valid at T+4) + 1 cycle to return to WAIT_IN.
- The block must not depend on the exact adder latency. It waits on add_valid.
- Packet of N elements: acc_valid asserts 1 cycle after the final accumulator update. For N=1, acc_valid asserts in the cycle after the handshake.
- in_valid held high during ISSUE/WAIT_ADD/DONE: no element is consumed. The element is accepted exactly once, when in_ready returns high.
- acc_valid and the next packet's first handshake never share a cycle. IDLE is entered after DONE.
- rst mid-packet: all state is cleared asynchronously and the partial sum is discarded. The adder shares rst, so any in-flight add is also cancelled. No acc_valid is produced for the aborted packet.
- acc_count saturates at 2^CNT_W-1 and the accumulation continues.

## Test plan
- 0x3F800000, 0x40000000, 0x40400000(last) (1+2+3) -> exactly 2 add_strt pulses; acc_out=0x40C00000, acc_count=3, acc_valid high 1 cycle.
- Single element 0x40490FDB with in_last -> no add_strt; acc_out=0x40490FDB, acc_count=1, acc_valid in the cycle after the handshake.
- 0x40A00000, 0xC0000000(last) (5 + -2) -> add_a=0x40A00000, add_b=0xC0000000 stable until add_valid; acc_out=0x40400000.
- in_valid held high across a 5-element packet of 0x3F800000 -> exactly 5 handshakes, 4 add_strt pulses, acc_out=0x40A00000, acc_count=5; the next packet starts only after DONE.
- add_busy forced high for 3 cycles on entering ISSUE -> add_strt delayed 3 cycles, single pulse, result unchanged.
- rst asserted while in WAIT_ADD of a 3-element packet -> outputs return to reset values immediately. A following packet 0x40000000, 0x40000000(last) gives 0x40800000, acc_count=2.

Source files
------------

// File: rtl/fp_accum_seq.sv
// Packet accumulator front-end for the multi-cycle FP adder: folds a valid/ready
// element stream into one sum per packet, issuing one serial add per element.
//
// state    | meaning
// IDLE     | waiting for first element of a packet (bypasses the adder)
// WAIT_IN  | partial sum held, waiting for next element
// ISSUE    | operands registered, pulse add_strt once adder is not busy
// WAIT_ADD | add in flight, waiting for add_valid
// DONE     | one-cycle result strobe
module fp_accum_seq #(
   parameter int EXP   = 8,
   parameter int MAN   = 23,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP+MAN:0]     in_data,
   input  logic                 in_last,
   output logic [EXP+MAN:0]     add_a,
   output logic [EXP+MAN:0]     add_b,
   output logic                 add_strt,
   input  logic                 add_busy,
   input  logic                 add_valid,
   input  logic [EXP+MAN:0]     add_sum,
   output logic [EXP+MAN:0]     acc_out,
   output logic                 acc_valid,
   output logic [CNT_W-1:0]     acc_count
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_IN  = 3'd1;
   localparam logic [2:0] S_ISSUE    = 3'd2;
   localparam logic [2:0] S_WAIT_ADD = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   logic [2:0]         r_state;
   logic [EXP+MAN:0]   r_acc;
   logic [EXP+MAN:0]   r_add_b;
   logic               r_last;
   logic [CNT_W-1:0]   r_cnt;
   logic [EXP+MAN:0]   r_acc_out;
   logic [CNT_W-1:0]   r_acc_count;

   logic               w_hs;
   logic [CNT_W-1:0]   w_cnt_inc;

   assign in_ready  = ~rst & ((r_state == S_IDLE) | (r_state == S_WAIT_IN));
   assign w_hs      = in_valid & in_ready;
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

   assign add_a     = r_acc;
   assign add_b     = r_add_b;
   assign add_strt  = (r_state == S_ISSUE) & ~add_busy;
   assign acc_valid = (r_state == S_DONE);
   assign acc_out   = r_acc_out;
   assign acc_count = r_acc_count;

   // The reported sum/count are loaded on entry to DONE so they are already
   // valid during the acc_valid cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_add_b     <= '0;
         r_last      <= 1'b0;
         r_cnt       <= '0;
         r_acc_out   <= '0;
         r_acc_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_acc <= in_data;
                  r_cnt <= CNT_W'(1);
                  if (in_last) begin
                     r_acc_out   <= in_data;
                     r_acc_count <= CNT_W'(1);
                     r_state     <= S_DONE;
                  end else begin
                     r_state <= S_WAIT_IN;
                  end
               end
            end
            S_WAIT_IN: begin
               if (w_hs) begin
                  r_add_b <= in_data;
                  r_last  <= in_last;
                  r_cnt   <= w_cnt_inc;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!add_busy) r_state <= S_WAIT_ADD;
            end
            S_WAIT_ADD: begin
               if (add_valid) begin
                  r_acc <= add_sum;
                  if (r_last) begin
                     r_acc_out   <= add_sum;
                     r_acc_count <= r_cnt;
                     r_state     <= S_DONE;
                  end else begin
                     r_state <= S_WAIT_IN;
                  end
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with a 4-cycle behavioural FP adder model
// (single-precision via real arithmetic, exact for the values used here).
module tb_fp_accum_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_last;
   logic [31:0] in_data;
   logic [31:0] add_a, add_b, add_sum, acc_out;
   logic        add_strt, add_busy, add_valid, acc_valid;
   logic [7:0]  acc_count;

   always #5 clk = ~clk;

   fp_accum_seq #(.EXP(8), .MAN(23), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .add_a(add_a), .add_b(add_b), .add_strt(add_strt), .add_busy(add_busy),
      .add_valid(add_valid), .add_sum(add_sum),
      .acc_out(acc_out), .acc_valid(acc_valid), .acc_count(acc_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_to(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for DUT", name);
   endtask

   function automatic real f2r(input logic [31:0] b);
      real m;
      int  e;
      if (b[30:0] == 31'd0) return 0.0;
      e = int'(b[30:23]) - 127;
      m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** e);
      return b[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      int          e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // adder model: strt seen in cycle T -> busy T+1..T+3, add_valid in T+4
   logic        m_busy = 1'b0, m_valid = 1'b0;
   logic [31:0] m_sum = 32'd0, pa = 32'd0, pb = 32'd0;
   logic        f_busy = 1'b0, f_valid = 1'b0;
   logic [31:0] f_sum = 32'd0;
   int          rem = 0;
   bit          start_pend;

   assign add_busy  = m_busy | f_busy;
   assign add_valid = m_valid | f_valid;
   assign add_sum   = f_valid ? f_sum : m_sum;

   initial begin
      forever begin
         @(negedge clk);
         start_pend = add_strt && !rst;
         if (start_pend) begin pa = add_a; pb = add_b; end
         @(posedge clk);
         #1;
         m_valid = 1'b0;
         if (rst) begin
            rem = 0;
            m_busy = 1'b0;
         end else begin
            if (rem > 0) begin
               rem--;
               if (rem == 0) begin
                  m_valid = 1'b1;
                  m_busy  = 1'b0;
                  m_sum   = r2f(f2r(pa) + f2r(pb));
               end
            end
            if (start_pend) begin
               rem = 3;
               m_busy = 1'b1;
            end
         end
      end
   end

   // monitor
   int cyc = 0, hs_cnt = 0, strt_cnt = 0, av_cnt = 0, overlap = 0, stab_err = 0;
   int last_hs_cyc = 0, last_strt_cyc = 0, last_addv_cyc = 0;
   logic [31:0] q_out[$];
   logic [7:0]  q_cnt[$];
   int          q_cyc[$];
   bit          inflight = 1'b0;
   logic [31:0] sa = 32'd0, sb = 32'd0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         inflight <= 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            hs_cnt <= hs_cnt + 1;
            last_hs_cyc <= cyc;
         end
         if (add_strt) begin
            strt_cnt <= strt_cnt + 1;
            last_strt_cyc <= cyc;
            inflight <= 1'b1;
            sa <= add_a;
            sb <= add_b;
         end else if (inflight && (add_a !== sa || add_b !== sb)) begin
            stab_err <= stab_err + 1;
         end
         if (add_valid) begin
            last_addv_cyc <= cyc;
            if (!add_strt) inflight <= 1'b0;
         end
         if (acc_valid) begin
            av_cnt <= av_cnt + 1;
            q_out.push_back(acc_out);
            q_cnt.push_back(acc_count);
            q_cyc.push_back(cyc);
            if (in_valid && in_ready) overlap <= overlap + 1;
         end
      end
   end

   task automatic push(input logic [31:0] d, input logic l, input string name);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
            break;
         end
      end
      if (!ok) fail_to(name);
   endtask

   task automatic wait_done(input int base, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (av_cnt > base) begin ok = 1'b1; break; end
         @(posedge clk);
      end
      if (!ok) fail_to(name);
      repeat (3) @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [3:0]       n;
      logic [7:0][31:0] d;
      logic [31:0]      sum;
      logic [7:0]       cnt;
   } vec_t;

   function automatic vec_t mk(input int n, input logic [31:0] a, b, c, e, f,
                               input logic [31:0] sum);
      vec_t v;
      v.n = 4'(n);
      v.d = '0;
      v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = e; v.d[4] = f;
      v.sum = sum;
      v.cnt = 8'(n);
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string name);
      int b_hs, b_st, b_av, n;
      b_hs = hs_cnt; b_st = strt_cnt; b_av = av_cnt;
      n = int'(v.n);
      for (int i = 0; i < n; i++) push(v.d[i], i == n - 1, name);
      in_valid = 1'b0;
      wait_done(b_av, name);
      chk({name, "_strobes"}, av_cnt - b_av, 1);
      chk({name, "_handshakes"}, hs_cnt - b_hs, n);
      chk({name, "_strts"}, strt_cnt - b_st, n - 1);
      if (q_out.size() > b_av) begin
         chk({name, "_sum"}, q_out[b_av], v.sum);
         chk({name, "_count"}, q_cnt[b_av], v.cnt);
         if (n == 1) chk({name, "_lat"}, q_cyc[b_av] - last_hs_cyc, 1);
         else        chk({name, "_lat"}, q_cyc[b_av] - last_addv_cyc, 1);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   vec_t tbl[7];

   initial begin
      int b_hs, b_st, b_av;
      tbl[0] = mk(3, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 32'h40C00000);
      tbl[1] = mk(1, 32'h40490FDB, 0, 0, 0, 0, 32'h40490FDB);
      tbl[2] = mk(2, 32'h40A00000, 32'hC0000000, 0, 0, 0, 32'h40400000);
      tbl[3] = mk(5, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40A00000);
      tbl[4] = mk(2, 32'h3F000000, 32'h3E800000, 0, 0, 0, 32'h3F400000);
      tbl[5] = mk(4, 32'h41200000, 32'h41A00000, 32'h41F00000, 32'h42200000, 0, 32'h42C80000);
      tbl[6] = mk(2, 32'h3FC00000, 32'hBFC00000, 0, 0, 0, 32'h00000000);

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      #3;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_add_strt", add_strt, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      chk("rst_acc_out", acc_out, 0);
      chk("rst_acc_valid", acc_valid, 0);
      chk("rst_acc_count", acc_count, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      for (int k = 0; k < 7; k++) begin
         run_vec(tbl[k], $sformatf("vec%0d", k));
         if (k == 2) begin
            chk("vec2_add_a", sa, 32'h40A00000);
            chk("vec2_add_b", sb, 32'hC0000000);
         end
      end

      // adder busy for 3 cycles on ISSUE entry
      b_st = strt_cnt; b_av = av_cnt;
      f_busy = 1'b1;
      push(32'h3F800000, 1'b0, "busy");
      push(32'h40000000, 1'b1, "busy");
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      f_busy = 1'b0;
      wait_done(b_av, "busy");
      chk("busy_strts", strt_cnt - b_st, 1);
      chk("busy_strt_delay", last_strt_cyc - last_hs_cyc, 4);
      if (q_out.size() > b_av) chk("busy_sum", q_out[b_av], 32'h40400000);

      // spurious add_valid while in WAIT_IN must be ignored
      b_av = av_cnt;
      push(32'h40400000, 1'b0, "spur");
      in_valid = 1'b0;
      @(posedge clk); #1;
      f_sum = 32'hDEADBEEF; f_valid = 1'b1;
      @(posedge clk); #1;
      f_valid = 1'b0;
      push(32'h40800000, 1'b1, "spur");
      in_valid = 1'b0;
      wait_done(b_av, "spur");
      if (q_out.size() > b_av) chk("spur_sum", q_out[b_av], 32'h40E00000);

      // in_valid held across 5-element packet and straight into the next one
      b_hs = hs_cnt; b_st = strt_cnt; b_av = av_cnt;
      for (int i = 0; i < 5; i++) push(32'h3F800000, i == 4, "held");
      push(32'h40490FDB, 1'b1, "held");
      in_valid = 1'b0;
      wait_done(b_av + 1, "held");
      chk("held_handshakes", hs_cnt - b_hs, 6);
      chk("held_strts", strt_cnt - b_st, 4);
      chk("held_strobes", av_cnt - b_av, 2);
      if (q_out.size() > b_av + 1) begin
         chk("held_sum", q_out[b_av], 32'h40A00000);
         chk("held_count", q_cnt[b_av], 5);
         chk("held_next_start", last_hs_cyc - q_cyc[b_av], 1);
         chk("held_next_sum", q_out[b_av + 1], 32'h40490FDB);
         chk("held_next_count", q_cnt[b_av + 1], 1);
      end

      // reset while WAIT_ADD
      b_av = av_cnt;
      push(32'h3F800000, 1'b0, "rstmid");
      push(32'h40000000, 1'b0, "rstmid");
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rstmid_in_ready", in_ready, 0);
      chk("rstmid_add_strt", add_strt, 0);
      chk("rstmid_add_a", add_a, 0);
      chk("rstmid_add_b", add_b, 0);
      chk("rstmid_acc_out", acc_out, 0);
      chk("rstmid_acc_valid", acc_valid, 0);
      chk("rstmid_acc_count", acc_count, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("rstmid_no_strobe", av_cnt - b_av, 0);
      run_vec(mk(2, 32'h40000000, 32'h40000000, 0, 0, 0, 32'h40800000), "after_rst");

      // count saturation at 255, accumulation continues
      b_st = strt_cnt; b_av = av_cnt;
      for (int i = 0; i < 300; i++) push(32'h3F800000, i == 299, "sat");
      in_valid = 1'b0;
      wait_done(b_av, "sat");
      chk("sat_strts", strt_cnt - b_st, 299);
      if (q_out.size() > b_av) begin
         chk("sat_sum", q_out[b_av], 32'h43960000);
         chk("sat_count", q_cnt[b_av], 255);
      end

      chk("operand_stability", stab_err, 0);
      chk("strobe_handshake_overlap", overlap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
